// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in/serial-out frame transmitter.
// Sends a start bit (0), WIDTH data bits LSB-first, then a stop bit (1).
// Each bit is held on Q for BIT_CYCLES clocks. The line idles high.
module piso_serial_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             Q,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_shift, w_shift;
  logic [BW-1:0]    r_bit,   w_bit;
  logic [CW-1:0]    r_cyc,   w_cyc;
  logic             r_q,     w_q;
  logic             r_busy,  w_busy;
  logic             r_done,  w_done;
  logic             w_bit_end;

  // State register: every frame-related flop, cleared asynchronously.
  always_ff @(posedge CK or posedge RST) begin
    // NOTE: the shift register is reset too, so that a frame abandoned by RST
    // leaves no stale data behind and every flop starts from a known value.
    if (RST) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_cyc   <= '0;
      r_q     <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so that every flop samples the
      // values present before the edge, whatever order the lines are in.
      r_state <= w_state;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_cyc   <= w_cyc;
      r_q     <= w_q;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // Next-state logic: bit timing, frame sequencing and the registered outputs.
  always_comb begin
    // NOTE: every output is given a default first (hold, or DONE low). A path
    // that left one unassigned would infer a latch.
    w_state   = r_state;
    w_shift   = r_shift;
    w_bit     = r_bit;
    w_cyc     = r_cyc;
    w_q       = r_q;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_bit_end = (r_cyc == CYC_LAST);

    if (r_state == S_IDLE) begin
      w_q = 1'b1;
      if (LOAD) begin
        w_shift = DIN;
        w_q     = 1'b0;
        w_busy  = 1'b1;
        w_cyc   = '0;
        w_state = S_START;
      end
    end else if (!w_bit_end) begin
      w_cyc = r_cyc + CW'(1);
    end else begin
      w_cyc = '0;
      case (r_state)
        S_START: begin
          w_q     = r_shift[0];
          w_bit   = '0;
          w_state = S_DATA;
        end
        S_DATA: begin
          if (r_bit < BIT_LAST) begin
            w_shift = r_shift >> 1;
            w_q     = w_shift[0];
            w_bit   = r_bit + BW'(1);
          end else begin
            w_q     = 1'b1;
            w_state = S_STOP;
          end
        end
        S_STOP: begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign Q    = r_q;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule
